mag_timer: RTL and testbench
============================

Name: mag_timer

Overview:
- Cook-time countdown for the micro-ondas controller: holds a 4-digit BCD time MM:SS entered from the keypad and counts it down once per second while the magnetron is on.
- Drives `time_over` into the on/off control, which produces the magnetron set/reset; consumes `mag_on` back from the magnetron latch.
- Also exports the digits to the display path.

Parameters:
- TICK_DIV, 100, clock cycles per one-second tick (board build overrides with the real clock frequency; min 2).
- PRE_W, 7, prescaler counter width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- mag_on  input  1  magnetron latch state; 1 = cooking, count down.
- Nclear  input  1  active-low clear button, already debounced.
- key_valid  input  1  one-cycle strobe, keypad digit available.
- key  input  4  keypad code; 0-9 are digits, 10-15 are ignored.
- add30  input  1  one-cycle strobe for +30 s; used only with MAG_TIMER_ADD30_EN.
- min_t  output  4  minutes tens, BCD.
- min_u  output  4  minutes units, BCD.
- sec_t  output  4  seconds tens, BCD, 0-9 (the entry "99" is legal).
- sec_u  output  4  seconds units, BCD.
- time_over  output  1  1 when the count is 00:00.
- done  output  1  one-cycle pulse when a tick brings the count to 00:00.

Behaviour:
- Reset (async, rst=1): all digits 0, prescaler 0, done 0, time_over 1.
- time_over is registered. It is updated in the same edge as the digits, so it always equals (digits == 0000).
- Per-edge priority: rst > Nclear low > key entry > add30 > tick decrement.
- Nclear=0: digits, prescaler and done all go to 0; time_over becomes 1 on the next edge. Applies whether mag_on is 0 or 1.
- Key entry: accepted only when mag_on=0, key_valid=1 and key<=9.
  - The digits shift left: min_t<=min_u, min_u<=sec_t, sec_t<=sec_u, sec_u<=key.
  - The old min_t is discarded.
  - If mag_on=1 or key>9, the entry is ignored and no state changes.
- Prescaler, while mag_on=1 and time_over=0:
  - Increments every cycle.
  - At TICK_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
- Prescaler, while mag_on=0: holds its value, so a paused cook resumes the fractional second.
- Prescaler, while time_over=1: cleared to 0.
- Tick decrement, BCD with borrow:
  - sec_u 0 becomes 9 and borrows from sec_t; otherwise sec_u-1.
  - sec_t 0 becomes 5 and borrows from min_u; otherwise sec_t-1. From 9, tens count 9,8,...
  - min_u 0 becomes 9 and borrows from min_t.
  - min_t decrements.
- Latency: the first tick comes TICK_DIV cycles after mag_on rises from a prescaler value of 0.
- Reaching zero: when a tick moves the count from 00:01 to 00:00, done=1 for exactly that edge's following cycle and time_over=1. No further decrement; the count never wraps below 00:00.
- Simultaneous events:
  - Nclear with a tick: the clear wins and done stays 0.
  - A key with mag_on=1: the key is ignored.
- mag_on dropping mid-second: the count freezes and time_over is unchanged.
- rst asserted mid-cook: immediate return to reset values.

Optional Feature:
- MAG_TIMER_ADD30_EN defined:
  - add30=1 adds 30 s in BCD, accepted whether mag_on is 0 or 1.
  - sec_t+3: if the result is >=6, subtract 6 and carry 1 into min_u (min_u 9 carries into min_t).
  - If the result would exceed 99:59, saturate to 99:59.
  - An add30 in the same cycle as a tick: the add is applied and the tick is dropped for that cycle; the prescaler still wraps.
  - An add30 from 00:00 gives 00:30 and time_over=0 on the next edge.
- MAG_TIMER_ADD30_EN undefined: the add30 port is present but ignored, with no logic generated.

Test Plan (TICK_DIV=4):
- Reset then keys 1,3,0 with mag_on=0 -> digits 0,1,3,0 (01:30), time_over=0; key 12 -> unchanged.
- Load 00:02, mag_on=1 -> 00:01 after 4 cycles, 00:00 after 8; done pulses once; time_over=1; the count holds at 00:00 over 20 further cycles.
- Load 01:00, mag_on=1 for 4 cycles -> 00:59; load 10:00, one tick -> 09:59.
- Load 00:05, mag_on=1 for 2 cycles, 0 for 10, then 1 -> the next decrement comes 2 cycles after mag_on returns; keys are ignored while mag_on=1.
- Nclear=0 during a cook at 00:03, on the cycle a tick is due -> 00:00, time_over=1, done=0; rst mid-cook -> all outputs at reset values asynchronously.
- With MAG_TIMER_ADD30_EN: 00:45 +add30 -> 01:15; 99:45 +add30 -> 99:59; 00:00 +add30 -> 00:30, time_over=0. Without the macro, add30 has no effect.

Source files
------------

// File: rtl/mag_timer.sv
// Cook-time countdown: 4-digit BCD MM:SS loaded from the keypad, decremented once per prescaler tick while mag_on.
// Optional +30 s button logic is compiled in with MAG_TIMER_ADD30_EN.
module mag_timer #(
   parameter int TICK_DIV = 100,
   parameter int PRE_W    = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mag_on,
   input  logic       Nclear,
   input  logic       key_valid,
   input  logic [3:0] key,
   input  logic       add30,
   output logic [3:0] min_t,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       time_over,
   output logic       done
);

   logic [PRE_W-1:0] pre, pre_n;
   logic [3:0]       mt_n, mu_n, st_n, su_n;
   logic [3:0]       d_mt, d_mu, d_st, d_su;
   logic             tick, done_n, to_n, key_ok;

   assign tick   = mag_on && !time_over && (pre == PRE_W'(TICK_DIV - 1));
   assign key_ok = key_valid && !mag_on && (key <= 4'd9);

   // BCD decrement with borrow; the borrow only ripples past digits that are zero
   always_comb begin
      d_mt = min_t;
      d_mu = min_u;
      d_st = sec_t;
      d_su = sec_u;
      if (sec_u != 4'd0) begin
         d_su = sec_u - 4'd1;
      end else begin
         d_su = 4'd9;
         if (sec_t != 4'd0) begin
            d_st = sec_t - 4'd1;
         end else begin
            d_st = 4'd5;
            if (min_u != 4'd0) begin
               d_mu = min_u - 4'd1;
            end else begin
               d_mu = 4'd9;
               d_mt = min_t - 4'd1;
            end
         end
      end
   end

`ifdef MAG_TIMER_ADD30_EN
   logic [3:0] a_st, a_mu, a_mt;
   logic       a_c1, a_c2, a_sat;

   always_comb begin
      a_st = sec_t + 4'd3;
      a_c1 = (a_st >= 4'd6);
      if (a_c1) a_st = a_st - 4'd6;
      a_mu = min_u + {3'b000, a_c1};
      a_c2 = (a_mu == 4'd10);
      if (a_c2) a_mu = 4'd0;
      a_mt = min_t + {3'b000, a_c2};
      a_sat = (a_mt == 4'd10);
   end
`else
   logic unused_add30;
   assign unused_add30 = add30;
`endif

   always_comb begin
      mt_n   = min_t;
      mu_n   = min_u;
      st_n   = sec_t;
      su_n   = sec_u;
      pre_n  = pre;
      done_n = 1'b0;
      // prescaler holds while paused so a resumed cook keeps its fractional second
      if (time_over)
         pre_n = '0;
      else if (mag_on)
         pre_n = tick ? '0 : pre + PRE_W'(1);

      if (!Nclear) begin
         mt_n  = 4'd0;
         mu_n  = 4'd0;
         st_n  = 4'd0;
         su_n  = 4'd0;
         pre_n = '0;
      end else if (key_ok) begin
         mt_n = min_u;
         mu_n = sec_t;
         st_n = sec_u;
         su_n = key;
`ifdef MAG_TIMER_ADD30_EN
      end else if (add30) begin
         if (a_sat) begin
            mt_n = 4'd9;
            mu_n = 4'd9;
            st_n = 4'd5;
            su_n = 4'd9;
         end else begin
            mt_n = a_mt;
            mu_n = a_mu;
            st_n = a_st;
         end
`endif
      end else if (tick) begin
         mt_n   = d_mt;
         mu_n   = d_mu;
         st_n   = d_st;
         su_n   = d_su;
         done_n = ({d_mt, d_mu, d_st, d_su} == 16'h0000);
      end
      to_n = ({mt_n, mu_n, st_n, su_n} == 16'h0000);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_t     <= 4'd0;
         min_u     <= 4'd0;
         sec_t     <= 4'd0;
         sec_u     <= 4'd0;
         pre       <= '0;
         done      <= 1'b0;
         time_over <= 1'b1;
      end else begin
         min_t     <= mt_n;
         min_u     <= mu_n;
         sec_t     <= st_n;
         sec_u     <= su_n;
         pre       <= pre_n;
         done      <= done_n;
         time_over <= to_n;
      end
   end

endmodule

// File: tb/tb_mag_timer.sv
// Directed bench for mag_timer with TICK_DIV=4; define MAG_TIMER_ADD30_EN to exercise the +30 s path.
module tb_mag_timer;

   logic       clk = 1'b0;
   logic       rst, mag_on, Nclear, key_valid, add30;
   logic [3:0] key;
   logic [3:0] min_t, min_u, sec_t, sec_u;
   logic       time_over, done;

   int checks = 0;
   int errors = 0;

   mag_timer #(.TICK_DIV(4), .PRE_W(3)) dut (
      .clk(clk), .rst(rst), .mag_on(mag_on), .Nclear(Nclear),
      .key_valid(key_valid), .key(key), .add30(add30),
      .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .time_over(time_over), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       nclear;
      logic       kv;
      logic [3:0] key;
      logic       mag;
      logic [15:0] dig;
      logic       to;
      logic       dn;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string nm, input logic [15:0] ed, input logic eto, input logic edn);
      checks++;
      if ({min_t, min_u, sec_t, sec_u} !== ed) begin
         errors++;
         $display("FAIL %s digits got %h want %h", nm, {min_t, min_u, sec_t, sec_u}, ed);
      end
      checks++;
      if (time_over !== eto) begin
         errors++;
         $display("FAIL %s time_over got %b want %b", nm, time_over, eto);
      end
      checks++;
      if (done !== edn) begin
         errors++;
         $display("FAIL %s done got %b want %b", nm, done, edn);
      end
   endtask

   // drive at negedge, let one posedge pass, return at the following negedge
   task automatic step(input logic nc, input logic kv, input logic [3:0] k, input logic mg, input logic ad);
      Nclear    = nc;
      key_valid = kv;
      key       = k;
      mag_on    = mg;
      add30     = ad;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_key(input logic [3:0] k);
      step(1'b1, 1'b1, k, 1'b0, 1'b0);
   endtask

   task automatic clear_all();
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 4'd3,  1'b0, 16'h0013, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 4'd0,  1'b0, 16'h0130, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 4'd12, 1'b0, 16'h0130, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'd0,  1'b0, 16'h0130, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 4'd2,  1'b0, 16'h0002, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0002, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0002, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0002, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 4'd5,  1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0};

      rst = 1'b1; mag_on = 1'b0; Nclear = 1'b1; key_valid = 1'b0; key = 4'd0; add30 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset", 16'h0000, 1'b1, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].nclear, tbl[i].kv, tbl[i].key, tbl[i].mag, 1'b0);
         check($sformatf("vec%0d", i), tbl[i].dig, tbl[i].to, tbl[i].dn);
      end

      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
         check($sformatf("hold_zero%0d", i), 16'h0000, 1'b1, 1'b0);
      end

      // 01:00 -> 00:59
      clear_all();
      load_key(4'd1); load_key(4'd0); load_key(4'd0);
      check("load_0100", 16'h0100, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("borrow_0059", 16'h0059, 1'b0, 1'b0);

      // 10:00 -> 09:59
      clear_all();
      load_key(4'd1); load_key(4'd0); load_key(4'd0); load_key(4'd0);
      check("load_1000", 16'h1000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("borrow_0959", 16'h0959, 1'b0, 1'b0);

      // pause keeps the fractional second
      clear_all();
      load_key(4'd5);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
      check("key_ignored_cook", 16'h0005, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
         check($sformatf("paused%0d", i), 16'h0005, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("resume1", 16'h0005, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("resume2", 16'h0004, 1'b0, 1'b0);

      // clear on the cycle a tick is due
      clear_all();
      load_key(4'd3);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("pre_tick", 16'h0003, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("clear_vs_tick", 16'h0000, 1'b1, 1'b0);
      load_key(4'd2);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("pre_cleared", 16'h0002, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      check("after_clear_tick", 16'h0001, 1'b0, 1'b0);

      // async reset mid-cook
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_async", 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      mag_on = 1'b0;

      clear_all();
      load_key(4'd4); load_key(4'd5);
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
`ifdef MAG_TIMER_ADD30_EN
      check("add30_0045", 16'h0115, 1'b0, 1'b0);
`else
      check("add30_off_0045", 16'h0045, 1'b0, 1'b0);
`endif
      clear_all();
      load_key(4'd9); load_key(4'd9); load_key(4'd4); load_key(4'd5);
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
`ifdef MAG_TIMER_ADD30_EN
      check("add30_sat", 16'h9959, 1'b0, 1'b0);
`else
      check("add30_off_9945", 16'h9945, 1'b0, 1'b0);
`endif
      clear_all();
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
`ifdef MAG_TIMER_ADD30_EN
      check("add30_zero", 16'h0030, 1'b0, 1'b0);
`else
      check("add30_off_zero", 16'h0000, 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
